// File: rtl/im_loader.sv
// im_loader: encodes symbolic MIPS commands and writes them to consecutive IM words.
// Define LOADER_DELAY_SLOT_EN to append a NOP word after every branch/jump.
module im_loader #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_kind,
  input  logic [4:0]    cmd_rs,
  input  logic [4:0]    cmd_rt,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_shamt,
  input  logic [15:0]   cmd_imm,
  input  logic [25:0]   cmd_target,
  input  logic          cmd_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic [AW:0]   words,
  output logic          done,
  output logic          err_ill,
  output logic          err_ovf
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef LOADER_DELAY_SLOT_EN
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t        state_q, state_d;
  logic          ready_q, ready_d, we_q, we_d, done_q, done_d, ill_q, ill_d, ovf_q, ovf_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, enc;
  logic [AW:0]   words_q, words_d, words_inc;
  logic          ill, acc, fills, last_ok;
  assign acc       = cmd_valid & ready_q;
  assign words_inc = words_q + (AW+1)'(1);
  assign fills     = words_inc == FULL;
`ifdef LOADER_DELAY_SLOT_EN
  logic pad_last_q, pad_last_d, is_br;
  assign is_br   = cmd_kind inside {5'd10, 5'd17, 5'd18, 5'd19, 5'd20};
  assign last_ok = cmd_last & ~is_br;
`else
  assign last_ok = cmd_last;
`endif
  always_comb begin
    enc = 32'h0;
    ill = 1'b0;
    case (cmd_kind)
      5'd0:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h21};
      5'd1:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h23};
      5'd2:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h20};
      5'd3:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h22};
      5'd4:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h24};
      5'd5:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h25};
      5'd6:    enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h2A};
      5'd7:    enc = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h00};
      5'd8:    enc = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h02};
      5'd9:    enc = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h03};
      5'd10:   enc = {6'h00, cmd_rs, 15'd0, 6'h08};
      5'd11:   enc = {6'h0F, 5'd0, cmd_rt, cmd_imm};
      5'd12:   enc = {6'h08, cmd_rs, cmd_rt, cmd_imm};
      5'd13:   enc = {6'h0D, cmd_rs, cmd_rt, cmd_imm};
      5'd14:   enc = {6'h0A, cmd_rs, cmd_rt, cmd_imm};
      5'd15:   enc = {6'h2B, cmd_rs, cmd_rt, cmd_imm};
      5'd16:   enc = {6'h23, cmd_rs, cmd_rt, cmd_imm};
      5'd17:   enc = {6'h04, cmd_rs, cmd_rt, cmd_imm};
      5'd18:   enc = {6'h05, cmd_rs, cmd_rt, cmd_imm};
      5'd19:   enc = {6'h02, cmd_target};
      5'd20:   enc = {6'h03, cmd_target};
      default: ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    done_d  = done_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
`ifdef LOADER_DELAY_SLOT_EN
    pad_last_d = pad_last_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        words_d = '0;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      LOAD: if (acc) begin
        we_d    = 1'b1;
        addr_d  = words_q[AW-1:0];
        wdata_d = enc;
        words_d = words_inc;
        ill_d   = ill_q | ill;
`ifdef LOADER_DELAY_SLOT_EN
        if (is_br && !fills) begin
          state_d    = PAD;
          pad_last_d = cmd_last;
        end else
`endif
        if (last_ok) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (fills) begin
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`ifdef LOADER_DELAY_SLOT_EN
      PAD: begin
        we_d    = 1'b1;
        addr_d  = words_q[AW-1:0];
        wdata_d = 32'h0;
        words_d = words_inc;
        state_d = (pad_last_q || fills) ? DONE : LOAD;
        done_d  = pad_last_q || fills;
        ovf_d   = !pad_last_q && fills;
      end
`endif
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD) && (words_d != FULL);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef LOADER_DELAY_SLOT_EN
      pad_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
`ifdef LOADER_DELAY_SLOT_EN
      pad_last_q <= pad_last_d;
`endif
    end
  end
  assign cmd_ready = ready_q;
  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign words     = words_q;
  assign done      = done_q;
  assign err_ill   = ill_q;
  assign err_ovf   = ovf_q;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench; a session-level model predicts every IM write and flag.
module tb_im_loader;
  localparam int AW = 4;
  localparam int DEPTH = 12;
  localparam logic [5:0] FUNCT [11] = '{6'h21, 6'h23, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
  localparam logic [5:0] IOP [8] = '{6'h0F, 6'h08, 6'h0D, 6'h0A, 6'h2B, 6'h23, 6'h04, 6'h05};
  logic clk = 0, rstn = 0, start = 0, cmd_valid = 0, cmd_last = 0;
  logic [4:0] cmd_kind = 0, cmd_rs = 0, cmd_rt = 0, cmd_rd = 0, cmd_shamt = 0;
  logic [15:0] cmd_imm = 0;
  logic [25:0] cmd_target = 0;
  logic cmd_ready, im_we, done, err_ill, err_ovf;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [AW:0] words;
  always #5 clk = ~clk;
  im_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .words(words), .done(done),
    .err_ill(err_ill), .err_ovf(err_ovf));
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   words;
    logic          done, ill, ovf;
  } wr_t;
  wr_t sb[$];
  wr_t e_mon;
  int vec = 0, errs = 0;
  // model session state: 0 idle, 1 loading, 2 pad pending, 3 done
  int m_st = 0, m_words = 0;
  bit m_done = 0, m_ill = 0, m_ovf = 0, m_pad_last = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [32:0] ref_enc(logic [4:0] k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [15:0] imm, logic [25:0] tg);
    int i = int'(k);
    bit shift = (i >= 7 && i <= 9);
    bit jr = (i == 10);
    if (i <= 10) return {1'b0, 6'h00, shift ? 5'd0 : rs, jr ? 5'd0 : rt, jr ? 5'd0 : rd, shift ? sh : 5'd0, FUNCT[i]};
    if (i <= 18) return {1'b0, IOP[i-11], (i == 11) ? 5'd0 : rs, rt, imm};
    if (i <= 20) return {1'b0, (i == 19) ? 6'h02 : 6'h03, tg};
    return {1'b1, 32'h0};
  endfunction
  function automatic void push_wr(logic [31:0] d);
    sb.push_back({AW'(m_words - 1), d, (AW+1)'(m_words), m_done, m_ill, m_ovf});
  endfunction
  always @(negedge clk) if (rstn && im_we) begin
    if (sb.size() == 0) begin
      vec++; errs++;
      $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wdata);
    end else begin
      e_mon = sb.pop_front();
      chk("im_addr", im_addr, e_mon.addr);
      chk("im_wdata", im_wdata, e_mon.data);
      chk("words_at_write", words, e_mon.words);
      chk("done_at_write", done, e_mon.done);
      chk("err_ill_at_write", err_ill, e_mon.ill);
      chk("err_ovf_at_write", err_ovf, e_mon.ovf);
    end
  end
  // one clock: drive inputs, check cmd_ready, advance model to post-edge state
  task automatic step(bit v, bit st, logic [4:0] k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                      logic [4:0] sh, logic [15:0] imm, logic [25:0] tg, bit last, output bit acc);
    bit rdy = (m_st == 1) && (m_words < DEPTH);
    bit br = k inside {5'd10, 5'd17, 5'd18, 5'd19, 5'd20};
    logic [32:0] r;
    start = st; cmd_valid = v; cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_shamt = sh; cmd_imm = imm; cmd_target = tg; cmd_last = last;
    chk("cmd_ready", cmd_ready, rdy);
    acc = v && rdy;
    if (m_st == 2) begin
      m_words++;
      if (m_pad_last) begin m_done = 1; m_st = 3; end
      else if (m_words == DEPTH) begin m_ovf = 1; m_done = 1; m_st = 3; end
      else m_st = 1;
      push_wr(32'h0);
    end else if (acc) begin
      r = ref_enc(k, rs, rt, rd, sh, imm, tg);
      m_words++;
      m_ill |= r[32];
`ifdef LOADER_DELAY_SLOT_EN
      if (br && m_words == DEPTH) begin m_ovf = 1; m_done = 1; m_st = 3; end
      else if (br) begin m_st = 2; m_pad_last = last; end
      else
`endif
      if (last) begin m_done = 1; m_st = 3; end
      else if (m_words == DEPTH) begin m_ovf = 1; m_done = 1; m_st = 3; end
      push_wr(r[31:0]);
    end else if (st && (m_st == 0 || m_st == 3)) begin
      m_st = 1; m_words = 0; m_done = 0; m_ill = 0; m_ovf = 0;
    end
    if (br && m_st == 99) acc = 0;
    @(posedge clk); #1;
  endtask
  task automatic idle(int n);
    bit a;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask
  task automatic begin_session();
    bit a;
    step($urandom % 2 == 1, 1, 5'd12, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 0, a);
  endtask
  task automatic dcmd(logic [4:0] k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                      logic [15:0] imm, logic [25:0] tg, bit last, bit gaps);
    bit acc = 0;
    int n = 0;
    while (!acc && m_st != 3) begin
      if (gaps && $urandom % 4 == 0) step(0, 0, k, rs, rt, rd, sh, imm, tg, last, acc);
      else step(1, 0, k, rs, rt, rd, sh, imm, tg, last, acc);
      n++;
      if (n > 40) begin
        vec++; errs++;
        $display("FAIL accept_timeout: got no acceptance expected one within 40 cycles");
        return;
      end
    end
  endtask
  task automatic rcmd(bit last, int ill_pct, bit gaps);
    logic [4:0] k = ($urandom % 100 < ill_pct) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
    dcmd(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), last, gaps);
  endtask
  task automatic end_session();
    idle(3);
    chk("done", done, m_done);
    chk("words", words, m_words);
    chk("err_ill", err_ill, m_ill);
    chk("err_ovf", err_ovf, m_ovf);
    chk("scoreboard_drained", sb.size(), 0);
  endtask
  task automatic check_all_zero(string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_words"}, words, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_ill"}, err_ill, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    // single addi with last
    begin_session();
    dcmd(5'd12, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1, 0);
    end_session();
    // back-to-back R-type, shift and lui run
    begin_session();
    dcmd(5'd0, 5'd8, 5'd9, 5'd10, 5'd3, 16'h0, 26'h0, 0, 0);
    dcmd(5'd7, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 0, 0);
    dcmd(5'd11, 5'd5, 5'd1, 5'd0, 5'd0, 16'hABCD, 26'h0, 0, 0);
    dcmd(5'd11, 5'd6, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 0, 0);
    dcmd(5'd11, 5'd7, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1, 0);
    end_session();
    // branch and jumps
    begin_session();
    dcmd(5'd17, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'h0, 0, 0);
    dcmd(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 0, 0);
    dcmd(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1, 0);
    end_session();
    // illegal kind then legal
    begin_session();
    dcmd(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h3FFFFFF, 0, 0);
    dcmd(5'd12, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1, 0);
    end_session();
    // overflow: offer more than DEPTH commands continuously
    begin_session();
    for (int i = 0; i < DEPTH + 4; i++) rcmd(0, 0, 0);
    end_session();
    // start while loading is ignored
    begin_session();
    rcmd(0, 0, 0);
    begin_session();
    rcmd(1, 0, 0);
    end_session();
    // reset one cycle after presenting an accepted command
    begin_session();
    rcmd(0, 0, 0);
    start = 0; cmd_valid = 1; cmd_kind = 5'd12; cmd_rt = 5'd9; cmd_imm = 16'h7777; cmd_last = 0;
    chk("cmd_ready_before_reset", cmd_ready, 1);
    @(negedge clk); rstn = 0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    cmd_valid = 0;
    sb.delete();
    m_st = 0; m_words = 0; m_done = 0; m_ill = 0; m_ovf = 0; m_pad_last = 0;
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    chk("cmd_ready_idle_after_reset", cmd_ready, 0);
    begin_session();
    dcmd(5'd13, 5'd4, 5'd5, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1, 0);
    end_session();
    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      int n = $urandom_range(1, 14);
      bit fin = ($urandom % 4 != 0);
      begin_session();
      for (int i = 0; i < n; i++) rcmd(fin && i == n - 1, 10, 1);
      end_session();
    end
    idle(2);
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
